wb_interconnect: RTL

//  Parametrised N-master x M-slave Wishbone classic shared-bus interconnect for the SoC.

---
 rtl/wb_pkg.sv | 25 ++
 rtl/wb_rr_arbiter.sv | 61 ++++++
 rtl/wb_interconnect.sv | 202 ++++++++++++++++++++
 3 files changed

// File: rtl/wb_pkg.sv
// Shared definitions for the Wishbone shared-bus interconnect.
//  - wb_state_e : bus FSM state (IDLE / BUSY / ERR)
//  - WB_DEF_*   : default widths, counts and decode map used by wb_interconnect
package wb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_ERR  = 2'd2
    } wb_state_e;

    localparam int WB_DEF_NUM_MASTERS = 2;
    localparam int WB_DEF_NUM_SLAVES  = 4;
    localparam int WB_DEF_DATA_WIDTH  = 32;
    localparam int WB_DEF_ADDR_WIDTH  = 32;
    localparam int WB_DEF_SEL_WIDTH   = 4;
    localparam int WB_DEF_TIMEOUT     = 255;

    // Default map for 4 slaves x 32-bit address: slave s owns the 256 MB window s<<28.
    // Any other slave count or address width must override both maps.
    localparam logic [127:0] WB_DEF_SLAVE_BASE = {32'h3000_0000, 32'h2000_0000,
                                                  32'h1000_0000, 32'h0000_0000};
    localparam logic [127:0] WB_DEF_SLAVE_MASK = {4{32'hF000_0000}};

endpackage

// File: rtl/wb_rr_arbiter.sv
// Round-robin arbiter with registered one-hot grant.
//  clk_i, rst_n_i : clock, async active-low reset
//  req            : request vector (one bit per master)
//  en             : load a new grant from req (bus idle)
//  last           : current owner is done; clear grant, advance pointer past it
//  grant          : registered one-hot grant, all-zero when the bus is free
module wb_rr_arbiter #(
    parameter int N = 2
) (
    input  logic         clk_i,
    input  logic         rst_n_i,
    input  logic [N-1:0] req,
    input  logic         en,
    input  logic         last,
    output logic [N-1:0] grant
);

    localparam int PW = (N > 1) ? $clog2(N) : 1;

    logic [PW-1:0] rr_ptr;
    logic [PW-1:0] next_ptr;
    logic [N-1:0]  pick;
    logic          found;
    int            idx;

    // First requester at or after rr_ptr, wrapping.
    always_comb begin
        pick  = '0;
        found = 1'b0;
        idx   = 0;
        for (int i = 0; i < N; i++) begin
            idx = (int'(rr_ptr) + i) % N;
            if (!found && req[idx]) begin
                pick[idx] = 1'b1;
                found     = 1'b1;
            end
        end
    end

    always_comb begin
        next_ptr = rr_ptr;
        for (int i = 0; i < N; i++) begin
            if (grant[i]) begin
                next_ptr = (i == N - 1) ? '0 : PW'(i + 1);
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            grant  <= '0;
            rr_ptr <= '0;
        end else if (last) begin
            grant  <= '0;
            rr_ptr <= next_ptr;
        end else if (en && found) begin
            grant  <= pick;
        end
    end

endmodule

// File: rtl/wb_interconnect.sv
// N-master x M-slave Wishbone classic shared-bus interconnect.
// Round-robin arbitration, base/mask decode (lowest slave index wins),
// error response for unmapped addresses and for slaves that never ack.
//
//  state   | meaning
//  --------+-----------------------------------------------------------
//  IDLE    | no owner; grant loaded from any m_cyc_i at the next edge
//  BUSY    | owner routed to decoded slave; watches cyc drop, miss, timeout
//  ERR     | one-cycle m_err_o pulse to the owner, then back to BUSY
//
// Ports (master m at [m*W +: W], slave s at [s*W +: W]):
//  clk_i, rst_n_i                           clock, async active-low reset
//  m_addr_i/m_data_i/m_we_i/m_sel_i/
//  m_stb_i/m_cyc_i                          master requests
//  m_ack_o/m_err_o/m_data_o                 master responses (owner only)
//  s_addr_o/s_data_o/s_we_o/s_sel_o         broadcast copy of owner signals
//  s_stb_o/s_cyc_o                          asserted on decoded slave only
//  s_ack_i/s_data_i                         slave responses
//  grant_o                                  one-hot current owner
module wb_interconnect
    import wb_pkg::*;
#(
    parameter int NUM_MASTERS    = WB_DEF_NUM_MASTERS,
    parameter int NUM_SLAVES     = WB_DEF_NUM_SLAVES,
    parameter int WB_DATA_WIDTH  = WB_DEF_DATA_WIDTH,
    parameter int WB_ADDR_WIDTH  = WB_DEF_ADDR_WIDTH,
    parameter int WB_SEL_WIDTH   = WB_DEF_SEL_WIDTH,
    parameter logic [NUM_SLAVES*WB_ADDR_WIDTH-1:0] SLAVE_BASE = WB_DEF_SLAVE_BASE,
    parameter logic [NUM_SLAVES*WB_ADDR_WIDTH-1:0] SLAVE_MASK = WB_DEF_SLAVE_MASK,
    parameter int TIMEOUT_CYCLES = WB_DEF_TIMEOUT
) (
    input  logic                                clk_i,
    input  logic                                rst_n_i,
    input  logic [NUM_MASTERS*WB_ADDR_WIDTH-1:0] m_addr_i,
    input  logic [NUM_MASTERS*WB_DATA_WIDTH-1:0] m_data_i,
    input  logic [NUM_MASTERS-1:0]               m_we_i,
    input  logic [NUM_MASTERS*WB_SEL_WIDTH-1:0]  m_sel_i,
    input  logic [NUM_MASTERS-1:0]               m_stb_i,
    input  logic [NUM_MASTERS-1:0]               m_cyc_i,
    output logic [NUM_MASTERS-1:0]               m_ack_o,
    output logic [NUM_MASTERS-1:0]               m_err_o,
    output logic [NUM_MASTERS*WB_DATA_WIDTH-1:0] m_data_o,
    output logic [NUM_SLAVES*WB_ADDR_WIDTH-1:0]  s_addr_o,
    output logic [NUM_SLAVES*WB_DATA_WIDTH-1:0]  s_data_o,
    output logic [NUM_SLAVES-1:0]                s_we_o,
    output logic [NUM_SLAVES*WB_SEL_WIDTH-1:0]   s_sel_o,
    output logic [NUM_SLAVES-1:0]                s_stb_o,
    output logic [NUM_SLAVES-1:0]                s_cyc_o,
    input  logic [NUM_SLAVES-1:0]                s_ack_i,
    input  logic [NUM_SLAVES*WB_DATA_WIDTH-1:0]  s_data_i,
    output logic [NUM_MASTERS-1:0]               grant_o
);

    localparam int NM  = NUM_MASTERS;
    localparam int NS  = NUM_SLAVES;
    localparam int AW  = WB_ADDR_WIDTH;
    localparam int DW  = WB_DATA_WIDTH;
    localparam int SW  = WB_SEL_WIDTH;
    localparam int MW  = (NM > 1) ? $clog2(NM) : 1;
    localparam int SIW = (NS > 1) ? $clog2(NS) : 1;
    localparam int TW  = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

    if (NM < 1 || NM > 8) begin : g_bad_masters
        $error("wb_interconnect: NUM_MASTERS must be 1..8");
    end
    if (NS < 1 || NS > 16) begin : g_bad_slaves
        $error("wb_interconnect: NUM_SLAVES must be 1..16");
    end
    if (SW * 8 != DW) begin : g_bad_sel
        $error("wb_interconnect: WB_SEL_WIDTH must equal WB_DATA_WIDTH/8");
    end
    if (TIMEOUT_CYCLES < 0) begin : g_bad_timeout
        $error("wb_interconnect: TIMEOUT_CYCLES must be >= 0");
    end

    wb_state_e       state;
    logic [NM-1:0]   grant;
    logic [MW-1:0]   owner;
    logic [TW-1:0]   tmo_cnt;

    logic [AW-1:0]   own_addr;
    logic [DW-1:0]   own_wdata;
    logic [SW-1:0]   own_sel;
    logic            own_we;
    logic            own_stb;
    logic            own_cyc;

    logic            hit;
    logic [SIW-1:0]  hit_idx;
    logic [NS-1:0]   hit_onehot;
    logic            slave_ack;
    logic [DW-1:0]   slave_rdata;

    logic            busy;
    logic            timeout_hit;
    logic            route;
    logic            xfer;

    wb_rr_arbiter #(.N(NM)) u_arb (
        .clk_i   (clk_i),
        .rst_n_i (rst_n_i),
        .req     (m_cyc_i),
        .en      (state == ST_IDLE),
        .last    (busy && !own_cyc),
        .grant   (grant)
    );

    assign grant_o = grant;
    assign busy    = (state == ST_BUSY);

    always_comb begin
        owner = '0;
        for (int m = 0; m < NM; m++) begin
            if (grant[m]) owner = MW'(m);
        end
    end

    // Masking with the grant keeps cyc/stb low when nobody owns the bus.
    assign own_cyc   = |(m_cyc_i & grant);
    assign own_stb   = |(m_stb_i & grant);
    assign own_we    = |(m_we_i & grant);
    assign own_addr  = m_addr_i[owner*AW +: AW];
    assign own_wdata = m_data_i[owner*DW +: DW];
    assign own_sel   = m_sel_i[owner*SW +: SW];

    // Scan downwards so the lowest matching index is the one left standing.
    always_comb begin
        hit     = 1'b0;
        hit_idx = '0;
        for (int s = NS - 1; s >= 0; s--) begin
            if ((own_addr & SLAVE_MASK[s*AW +: AW]) ==
                (SLAVE_BASE[s*AW +: AW] & SLAVE_MASK[s*AW +: AW])) begin
                hit     = 1'b1;
                hit_idx = SIW'(s);
            end
        end
    end

    assign hit_onehot  = NS'(1) << hit_idx;
    assign slave_ack   = s_ack_i[hit_idx];
    assign slave_rdata = s_data_i[hit_idx*DW +: DW];

    assign timeout_hit = (TIMEOUT_CYCLES != 0) && (tmo_cnt == TW'(TIMEOUT_CYCLES));
    assign route       = busy && own_cyc && hit && !timeout_hit;
    assign xfer        = route && own_stb;

    assign s_addr_o = {NS{own_addr}};
    assign s_data_o = {NS{own_wdata}};
    assign s_sel_o  = {NS{own_sel}};
    assign s_we_o   = {NS{own_we}};
    assign s_cyc_o  = route ? hit_onehot : '0;
    assign s_stb_o  = xfer  ? hit_onehot : '0;

    assign m_ack_o = (xfer && slave_ack) ? grant : '0;
    assign m_err_o = (state == ST_ERR)   ? grant : '0;

    always_comb begin
        m_data_o = '0;
        for (int m = 0; m < NM; m++) begin
            if (grant[m] && busy && hit) m_data_o[m*DW +: DW] = slave_rdata;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state   <= ST_IDLE;
            tmo_cnt <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    tmo_cnt <= '0;
                    if (|m_cyc_i) state <= ST_BUSY;
                end
                ST_BUSY: begin
                    if (!own_cyc) begin
                        state   <= ST_IDLE;
                        tmo_cnt <= '0;
                    end else if (own_stb && !hit) begin
                        state   <= ST_ERR;
                        tmo_cnt <= '0;
                    end else if (timeout_hit) begin
                        state   <= ST_ERR;
                        tmo_cnt <= '0;
                    end else if (xfer && slave_ack) begin
                        tmo_cnt <= '0;
                    end else if (xfer && TIMEOUT_CYCLES != 0) begin
                        tmo_cnt <= tmo_cnt + TW'(1);
                    end
                end
                ST_ERR: begin
                    state   <= ST_BUSY;
                    tmo_cnt <= '0;
                end
                default: begin
                    state   <= ST_IDLE;
                    tmo_cnt <= '0;
                end
            endcase
        end
    end

endmodule
